// File: rtl/cpu_fetch_ctrl.sv
// cpu_fetch_ctrl: instruction fetch / execute sequencer.
// Owns the program counter and fetches one instruction word at a time over a
// req/ack handshake. Each word is held in the instruction register for a
// stall-able execute phase. After execute, the PC takes the branch target or
// the sequential increment. The sequencer halts on the all-ones opcode or
// when a fetch times out. Every output is decoded from registers only.
module cpu_fetch_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int INSN_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INSN_W-1:0] imem_data_i,
  output logic [INSN_W-1:0] ir_o,
  output logic              ir_valid_o,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              halt_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [INSN_W-1:0] HALT_OP  = '1;
  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  // Next-state and datapath decisions for the fetch/execute sequence.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_REQ;
      end

      // run_i is deliberately ignored here: a request always completes or
      // times out.
      S_REQ: begin
        if (imem_ack_i) begin
          ir_d    = imem_data_i;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // The halt opcode takes priority over stall and branch.
      S_EXEC: begin
        if (ir_q == HALT_OP) begin
          state_d = S_HALT;
        end else if (!stall_i) begin
          pc_d    = branch_i ? branch_addr_i : pc_q + ADDR_W'(1);
          state_d = run_i ? S_REQ : S_IDLE;
        end
      end

      // Terminal until reset; err_q holds its value.
      default: state_d = S_HALT;
    endcase
  end

  // State registers with synchronous active-low reset; reset wins over all.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    if (!rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ);
  assign ir_valid_o  = (state_q == S_EXEC);
  assign halt_o      = (state_q == S_HALT);
  assign imem_addr_o = pc_q;
  assign ir_o        = ir_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Self-checking bench for cpu_fetch_ctrl: directed scenarios plus randomized
// traffic. A behavioural reference model is stepped once per clock alongside
// the DUT.
module tb_cpu_fetch_ctrl;

  localparam int ADDR_W  = 4;
  localparam int INSN_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              ack = 1'b0;
  logic [INSN_W-1:0] data = '0;
  logic              stall = 1'b0;
  logic              branch = 1'b0;
  logic [ADDR_W-1:0] baddr = '0;

  logic              imem_req_o, ir_valid_o, halt_o, err_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [INSN_W-1:0] ir_o;

  int checks = 0;
  int errors = 0;

  logic [INSN_W-1:0] mem [16];

  // Reference model, described at the level of the sequencer's phases.
  typedef enum {M_IDLE, M_REQ, M_EXEC, M_HALT} phase_e;
  phase_e      m_phase;
  int          m_pc, m_cnt;
  logic [7:0]  m_ir;
  bit          m_err;

  always #5 clk = ~clk;

  cpu_fetch_ctrl #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (ack),
    .imem_data_i  (data),
    .ir_o         (ir_o),
    .ir_valid_o   (ir_valid_o),
    .stall_i      (stall),
    .branch_i     (branch),
    .branch_addr_i(baddr),
    .halt_o       (halt_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules for one clock, using the inputs present at the edge.
  task automatic model_update();
    if (!rst) begin
      m_phase = M_IDLE; m_pc = 0; m_ir = 8'h00; m_cnt = 0; m_err = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (run) m_phase = M_REQ;
        M_REQ: begin
          if (ack) begin
            m_ir = data; m_cnt = 0; m_phase = M_EXEC;
          end else begin
            m_cnt++;
            if (m_cnt == TIMEOUT) begin
              m_phase = M_HALT; m_err = 1;
            end
          end
        end
        M_EXEC: begin
          if (m_ir == 8'hFF) m_phase = M_HALT;
          else if (!stall) begin
            m_pc    = branch ? int'(baddr) : (m_pc + 1) % 16;
            m_phase = run ? M_REQ : M_IDLE;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: advance model at the edge, compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("req",   imem_req_o,  m_phase == M_REQ);
    check("valid", ir_valid_o,  m_phase == M_EXEC);
    check("halt",  halt_o,      m_phase == M_HALT);
    check("err",   err_o,       m_err);
    check("addr",  imem_addr_o, m_pc);
    check("ir",    ir_o,        m_ir);
  endtask

  // Two reset cycles, then run=1 and one edge so the sequencer sits in REQ.
  task automatic do_reset();
    rst = 1'b0; run = 1'b0; ack = 1'b0; stall = 1'b0; branch = 1'b0;
    step(); step();
    rst = 1'b1; run = 1'b1;
    step();
  endtask

  // One instruction starting in REQ: ack after wait_c idle REQ cycles, stall
  // stall_c cycles in EXEC, then release with the given branch decision.
  task automatic fetch_one(input int wait_c, input int stall_c, input bit br,
                           input logic [ADDR_W-1:0] tgt,
                           output logic [ADDR_W-1:0] addr, output logic [7:0] ir,
                           output int req_c, output int val_c);
    req_c = 0; val_c = 0;
    addr  = imem_addr_o;
    if (imem_req_o) req_c++;
    ack = 1'b0;
    for (int i = 0; i < wait_c; i++) begin
      step();
      if (imem_req_o) req_c++;
      check("addr_stable", imem_addr_o, addr);
    end
    ack = 1'b1; data = mem[imem_addr_o];
    step();
    ack = 1'b0;
    ir = ir_o;
    if (ir_valid_o) val_c++;
    stall = 1'b1;
    for (int i = 0; i < stall_c; i++) begin
      step();
      if (ir_valid_o) val_c++;
    end
    stall = 1'b0; branch = br; baddr = tgt;
    step();
    branch = 1'b0;
  endtask

  logic [ADDR_W-1:0] a;
  logic [7:0]        ir;
  int                rc, vc, cnt, halt_run;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);

    // Sequential fetch with zero-wait memory.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
      check("seq_addr", a, i);
      check("seq_ir", ir, 8'h10 + i);
      check("seq_valid_cycles", vc, 1);
      check("seq_req_cycles", rc, 1);
    end

    // Branch at address 2 to 9, then to 15, then wrap to 0.
    do_reset();
    fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
    fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
    fetch_one(0, 0, 1'b1, 4'd9, a, ir, rc, vc);
    check("br_from", a, 2);
    fetch_one(0, 0, 1'b1, 4'd15, a, ir, rc, vc);
    check("br_target", a, 9);
    fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
    check("at_15", a, 15);
    check("wrap_addr", imem_addr_o, 0);

    // Wait states and stall.
    fetch_one(2, 4, 1'b0, '0, a, ir, rc, vc);
    check("wait_req_cycles", rc, 3);
    check("stall_valid_cycles", vc, 5);
    check("stall_ir", ir, 8'h10);
    check("after_stall_addr", imem_addr_o, 1);

    // Halt opcode at address 5.
    mem[5] = 8'hFF;
    do_reset();
    for (int i = 0; i < 6; i++) fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
    check("halt_op_addr", a, 5);
    check("halt_op_valid", vc, 1);
    check("halt_op_halt", halt_o, 1);
    check("halt_op_err", err_o, 0);
    cnt = 0;
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ack = 1'b1; stall = 1'(i % 2); branch = 1'b1;
      step();
      if (imem_req_o) cnt++;
    end
    ack = 1'b0; stall = 1'b0; branch = 1'b0;
    check("halt_req_count", cnt, 0);
    check("halt_hold_addr", imem_addr_o, 5);
    mem[5] = 8'h15;

    // Fetch timeout.
    do_reset();
    ack = 1'b0;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req_o) cnt++;
    end
    check("timeout_req_cycles", cnt, TIMEOUT);
    check("timeout_halt", halt_o, 1);
    check("timeout_err", err_o, 1);

    // Reset in a REQ cycle that also carries an ack.
    do_reset();
    fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
    fetch_one(0, 0, 1'b0, '0, a, ir, rc, vc);
    check("pre_rst_addr", imem_addr_o, 2);
    rst = 1'b0; ack = 1'b1; data = 8'h5A;
    step();
    ack = 1'b0;
    check("rst_req", imem_req_o, 0);
    check("rst_ir", ir_o, 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_valid", ir_valid_o, 0);
    rst = 1'b1; run = 1'b1;
    step();
    check("post_rst_req", imem_req_o, 1);
    check("post_rst_addr", imem_addr_o, 0);

    // Randomized traffic against the model.
    halt_run = 0;
    for (int i = 0; i < 4000; i++) begin
      run    = ($urandom_range(0, 3) != 0);
      ack    = 1'($urandom_range(0, 1));
      data   = ($urandom_range(0, 40) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      stall  = ($urandom_range(0, 9) < 3);
      branch = ($urandom_range(0, 3) == 0);
      baddr  = 4'($urandom);
      halt_run = (m_phase == M_HALT) ? halt_run + 1 : 0;
      rst    = !(($urandom_range(0, 199) == 0) || halt_run > 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
